// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared types, constants and GF(2^8) helpers for the AES engine.
// Rev    : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [1:0]   aes_fsm_t;

    localparam aes_fsm_t c_st_idle   = 2'd0;
    localparam aes_fsm_t c_st_expand = 2'd1;
    localparam aes_fsm_t c_st_round  = 2'd2;

    localparam logic [7:0] c_rcon [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                            8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic int aes_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int aes_nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic aes_word_t mix_column(input aes_word_t c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module : aes_sbox
// Brief  : Combinational AES forward S-box (GF(2^8) inverse + affine map).
// Rev    : 1.0
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;
    logic [7:0] w_pow;

    // Inverse as x^254 by square-and-multiply; 0 maps to 0 naturally.
    always_comb begin
        w_inv = 8'h01;
        w_pow = i_byte;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) w_inv = gf_mul(w_inv, w_pow);
            w_pow = gf_mul(w_pow, w_pow);
        end
    end

    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/aes_engine.sv
`default_nettype none
// ============================================================================
// Module : aes_engine
// Brief  : Iterative AES-128/192/256 encryptor, one round per clock, with a
//          stored key schedule. Optional CTR mode under AES_ENGINE_CTR_EN.
// Rev    : 1.0
// ============================================================================
module aes_engine
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key,
    input  logic                key_load,
    input  logic [127:0]        pt,
    input  logic                start,
`ifdef AES_ENGINE_CTR_EN
    input  logic [127:0]        iv,
    input  logic                iv_load,
`endif
    output logic [127:0]        ct,
    output logic                ready,
    output logic                key_valid
);

    localparam int NK = aes_nk(KEY_BITS);
    localparam int NR = aes_nr(KEY_BITS);
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_engine: KEY_BITS must be 128, 192 or 256");
    end

    aes_fsm_t   r_fsm;
    logic [5:0] r_widx;
    logic [2:0] r_kmod;
    logic [3:0] r_rci;
    logic [3:0] r_round;
    aes_state_t r_state;
    aes_state_t r_ct;
    logic       r_kv;
    aes_word_t  r_w [0:NW-1];

    aes_word_t  w_prev, w_back, w_sub_in, w_sub, w_temp;
    aes_state_t w_sb, w_sr, w_mc, w_rk, w_next, w_rk0, w_blk_in, w_result;

    // Key expansion datapath
    assign w_prev   = r_w[r_widx - 6'd1];
    assign w_back   = r_w[r_widx - 6'(NK)];
    assign w_sub_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar k = 0; k < 4; k++) begin : g_subword_sbox
        aes_sbox u_sbox (.i_byte(w_sub_in[31-8*k -: 8]), .o_byte(w_sub[31-8*k -: 8]));
    end

    always_comb begin
        w_temp = w_prev;
        if (r_kmod == 3'd0)
            w_temp = w_sub ^ {c_rcon[r_rci], 24'h0};
        else if (NK == 8 && r_kmod == 3'd4)
            w_temp = w_sub;
    end

    // Round datapath; byte k of the state is row k%4, column k/4
    for (genvar k = 0; k < 16; k++) begin : g_round_sbox
        aes_sbox u_sbox (.i_byte(r_state[127-8*k -: 8]), .o_byte(w_sb[127-8*k -: 8]));
    end

    always_comb begin
        w_sr = '0;
        w_mc = '0;
        w_rk = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++)
                w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mix_column(w_sr[127-32*c -: 32]);
            w_rk[127-32*c -: 32] = r_w[{r_round, 2'b00} + 6'(c)];
        end
        w_next = ((r_round == 4'(NR)) ? w_sr : w_mc) ^ w_rk;
    end

    assign w_rk0 = {r_w[0], r_w[1], r_w[2], r_w[3]};

`ifdef AES_ENGINE_CTR_EN
    logic [127:0] r_ctr;
    logic [127:0] r_pt;

    // A same-cycle iv_load feeds the new counter straight into this block
    assign w_blk_in = iv_load ? iv : r_ctr;
    assign w_result = w_next ^ r_pt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctr <= '0;
            r_pt  <= '0;
        end else if (r_fsm == c_st_idle) begin
            if (iv_load) r_ctr <= iv;
            if (start && r_kv && !key_load) r_pt <= pt;
        end else if (r_fsm == c_st_round && r_round == 4'(NR)) begin
            r_ctr <= {r_ctr[127:32], r_ctr[31:0] + 32'd1};
        end
    end
`else
    assign w_blk_in = pt;
    assign w_result = w_next;
`endif

    always_ff @(posedge clk) begin
        if (!reset && r_fsm == c_st_idle && key_load) begin
            for (int j = 0; j < NK; j++)
                r_w[j] <= key[KEY_BITS-1-32*j -: 32];
        end else if (!reset && r_fsm == c_st_expand) begin
            r_w[r_widx] <= w_back ^ w_temp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm   <= c_st_idle;
            r_widx  <= '0;
            r_kmod  <= '0;
            r_rci   <= '0;
            r_round <= '0;
            r_state <= '0;
            r_ct    <= '0;
            r_kv    <= 1'b0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (key_load) begin
                        r_fsm  <= c_st_expand;
                        r_kv   <= 1'b0;
                        r_widx <= 6'(NK);
                        r_kmod <= '0;
                        r_rci  <= '0;
                    end else if (start && r_kv) begin
                        r_fsm   <= c_st_round;
                        r_state <= w_blk_in ^ w_rk0;
                        r_round <= 4'd1;
                    end
                end
                c_st_expand: begin
                    r_kmod <= (r_kmod == 3'(NK-1)) ? 3'd0 : r_kmod + 3'd1;
                    if (r_kmod == 3'd0) r_rci <= r_rci + 4'd1;
                    r_widx <= r_widx + 6'd1;
                    if (r_widx == 6'(NW-1)) begin
                        r_fsm  <= c_st_idle;
                        r_kv   <= 1'b1;
                        r_widx <= '0;
                    end
                end
                c_st_round: begin
                    r_state <= w_next;
                    r_round <= r_round + 4'd1;
                    if (r_round == 4'(NR)) begin
                        r_ct    <= w_result;
                        r_fsm   <= c_st_idle;
                        r_round <= '0;
                    end
                end
                default: r_fsm <= c_st_idle;
            endcase
        end
    end

    assign ct        = r_ct;
    assign ready     = (r_fsm == c_st_idle);
    assign key_valid = r_kv;

endmodule
`default_nettype wire

// File: doc/aes_engine.md
# aes_engine

Iterative AES-128/192/256 encryption engine. It is the parametrised successor of the team's fixed AES block. It expands a loaded key into a stored round-key schedule once, then encrypts one 128-bit block per request at one round per clock. An optional counter (CTR) mode lets the stream layer of the TPM interface use it directly as a keystream generator.

## Interface
- `KEY_BITS`, default 128: key size. Legal values are 128, 192 and 256; any other value is an elaboration error.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `key`  in  KEY_BITS  cipher key. FIPS-197 byte 0 sits at `[KEY_BITS-1 -: 8]`.
- `key_load`  in  1  one-cycle request to expand `key`.
- `pt`  in  128  plaintext. FIPS byte 0 sits at `[127:120]`.
- `start`  in  1  one-cycle request to encrypt `pt`.
- `ct`  out  128  result. Held stable until the next completion.
- `ready`  out  1  idle; `start` and `key_load` are accepted.
- `key_valid`  out  1  a complete key schedule is stored.
- CTR mode only:
  - `iv`  in  128  initial counter block.
  - `iv_load`  in  1  one-cycle request to load `iv` into the counter.

## Operation
- Nk = KEY_BITS/32. Nr = Nk+6. Round-key store holds 4·(Nr+1) 32-bit words.
- FSM states:
  - IDLE. `ready`=1.
  - EXPAND. `ready`=0.
  - ROUND. `ready`=0.
- IDLE to EXPAND: on `key_load`.
  - `key` is latched into words w[0..Nk-1].
  - `key_valid` drops to 0.
- EXPAND: one word w[i] per cycle, for i = Nk .. 4(Nr+1)-1.
  - Standard rule: RotWord/SubWord/Rcon applied when i mod Nk = 0.
  - Extra SubWord applied when Nk=8 and i mod 8 = 4.
  - After the last word: `key_valid`=1, go to IDLE.
- IDLE to ROUND: on `start` when `key_valid`=1.
  - State register is loaded with input XOR rk[0]. Round counter is set to 1.
  - ECB input: `pt`.
  - CTR input: the counter.
- ROUND: one full round per cycle (SubBytes, ShiftRows, MixColumns, AddRoundKey rk[r]).
  - Round Nr omits MixColumns.
  - After round Nr: `ct` is updated and the FSM goes to IDLE.
- `start` with `key_valid`=0: ignored. `ready` stays 1 and `ct` is unchanged.
- `start` or `key_load` outside IDLE: ignored.
- `start` and `key_load` in the same cycle: `key_load` wins and `start` is dropped.
- `ct` is unchanged during EXPAND.
- Reset, including mid-operation:
  - FSM goes to IDLE. Round and word counters clear.
  - Outputs: `ready`=1, `key_valid`=0, `ct`=0.
  - CTR counter resets to 0.
  - The in-flight request is lost.

## Timing
- Encryption latency: with `start` sampled at edge E0, `ct` is valid and `ready`=1 after edge E0+Nr.
  - That is 10, 12 or 14 cycles for 128/192/256.
- A new `start` is accepted on the same edge at which `ready` is first seen high.
- Key expansion latency: 4(Nr+1)−Nk cycles after the `key_load` edge.
  - That is 40, 46 or 52 cycles for 128/192/256.
- `ready` is a level, not a pulse. It falls on the edge that accepts a request.

## Configuration
- Macro: `AES_ENGINE_CTR_EN`.
- Defined:
  - `iv` and `iv_load` exist.
  - `iv_load` is accepted only in IDLE and sets counter = `iv`.
  - `start` encrypts the counter. `pt` is latched at the `start` edge.
  - On completion, `ct` = E(counter) XOR latched `pt`.
  - On the same edge, counter[31:0] increments mod 2^32; counter[127:32] is unchanged.
  - `iv_load` together with `start` in the same cycle: `iv_load` applies first, so the block uses the new `iv`.
- Undefined:
  - The ports are absent and there is no counter logic.
  - `ct` = E(`pt`) (ECB).

## Structure
- Package `aes_pkg` holds:
  - Nk/Nr constant functions.
  - The Rcon table.
  - A 128-bit state typedef and a 32-bit word typedef.
  - The FSM state enum.
  - The GF(2^8) xtime function.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box.
  - 16 instances serve the round datapath and 4 serve SubWord.

## Test plan
- AES-128: load key 000102…0f, start with pt 00112233445566778899aabbccddeeff.
  - `ct`=69c4e0d86a7b0430d8cdb78070b4c55a.
  - `ready` returns exactly 10 cycles after `start`; `key_valid` rose 40 cycles after `key_load`.
- KEY_BITS=192 and 256, same pt:
  - Key 00…17 gives `ct`=dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles.
  - Key 00…1f gives `ct`=8ea2b7ca516745bfeafc49904b496089 at 14 cycles.
- Handshake edge cases:
  - `start` before any `key_load`: ignored, and `ct` stays 0.
  - `start` and `key_load` in the same cycle: EXPAND runs and no encryption occurs.
  - `start` during ROUND: ignored, and exactly one completion is seen.
- Reset at round 5 of an encryption:
  - Next cycle shows `ready`=1, `key_valid`=0, `ct`=0.
  - A subsequent `start` with no new key is ignored.
- CTR (macro defined):
  - Key 2b7e151628aed2a6abf7158809cf4f3c, `iv` f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff.
  - pt 6bc1bee22e409f96e93d7e117393172a gives `ct` 874d6191b620e3261bef6864990db6ce.
  - The following pt ae2d8a571e03ac9c9eb76fac45af8e51 gives `ct` 9806f66b7970fdff8617187bb9fffdff.
- CTR wrap: `iv` with low word ffffffff.
  - After one block, the counter's low word is 00000000 and the upper 96 bits are unchanged.
